// File: rtl/sn_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module   : sn_pkg                                                        |
// | Purpose  : Shared widths and FSM state type for the result serializer.   |
// | Revision : 1.0  initial release                                          |
// ----------------------------------------------------------------------------
package sn_pkg;

   localparam int SN_FRAME_BITS = 9;
   localparam int SN_WORD_W     = 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } sn_ser_state_t;

endpackage
`default_nettype wire

// File: rtl/sn_result_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module   : sn_result_fifo                                                |
// | Purpose  : Small synchronous FIFO holding 9-bit probability words.       |
// |            Pointers carry one extra wrap bit to tell full from empty.    |
// | Revision : 1.0  initial release                                          |
// ----------------------------------------------------------------------------
module sn_result_fifo
   import sn_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [SN_FRAME_BITS-1:0] push_data,
   input  logic                     pop,
   output logic [SN_FRAME_BITS-1:0] pop_data,
   output logic                     full,
   output logic                     empty
);

   localparam int c_aw = $clog2(DEPTH);

   logic [SN_FRAME_BITS-1:0] r_mem [DEPTH];
   logic [c_aw:0]            r_wr_ptr;
   logic [c_aw:0]            r_rd_ptr;

   // Pointer update; the caller only pushes when there is room (or a pop frees it).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // Storage array; contents are don't-care while the entry is not valid.
   always_ff @(posedge clk) begin
      if (push) r_mem[r_wr_ptr[c_aw-1:0]] <= push_data;
   end

   assign pop_data = r_mem[r_rd_ptr[c_aw-1:0]];
   assign empty    = (r_wr_ptr == r_rd_ptr);
   assign full     = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                     (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);

endmodule
`default_nettype wire

// File: rtl/sn_result_serializer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module   : sn_result_serializer                                          |
// | Purpose  : Buffers strobed window results and re-emits the 9-bit         |
// |            probability as an LSB-first framed serial stream.             |
// | Options  : SN_SER_SATURATE_EN - overflowed words are stored as 9'h1FF.   |
// | Revision : 1.0  initial release                                          |
// ----------------------------------------------------------------------------
module sn_result_serializer
   import sn_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int FRAME_GAP = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 result_valid,
   input  logic [SN_WORD_W-1:0] result,
   output logic                 ser_bit,
   output logic                 ser_frame,
   output logic                 busy,
   output logic                 fifo_full,
   output logic                 ovf_seen,
   output logic [7:0]           drop_count
);

   localparam int                 c_gap_w    = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
   localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(FRAME_GAP - 1);
   localparam logic [3:0]         c_bit_last = 4'(SN_FRAME_BITS - 1);

   sn_ser_state_t            r_state;
   sn_ser_state_t            w_state_next;
   logic [SN_FRAME_BITS-1:0] r_shreg;
   logic [3:0]               r_bitcnt;
   logic [c_gap_w-1:0]       r_gapcnt;
   logic                     r_ser_bit;
   logic                     r_ser_frame;
   logic                     r_ovf_seen;
   logic [7:0]               r_drop_count;

   logic                     w_empty;
   logic                     w_full;
   logic                     w_pop;
   logic                     w_accept;
   logic                     w_gap_done;
   logic [SN_FRAME_BITS-1:0] w_head;
   logic [SN_FRAME_BITS-1:0] w_store;

   assign w_gap_done = (r_state == GAP) && (r_gapcnt == c_gap_last);
   assign w_pop      = !w_empty && ((r_state == IDLE) || w_gap_done);
   // A full FIFO still takes a word when the head leaves on the same edge.
   assign w_accept   = result_valid && (!w_full || w_pop);

`ifdef SN_SER_SATURATE_EN
   assign w_store = result[SN_WORD_W-1] ? {SN_FRAME_BITS{1'b1}} : result[SN_FRAME_BITS-1:0];
`else
   assign w_store = result[SN_FRAME_BITS-1:0];
`endif

   sn_result_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (w_accept),
      .push_data (w_store),
      .pop       (w_pop),
      .pop_data  (w_head),
      .full      (w_full),
      .empty     (w_empty)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_next;
   end

   // Next-state logic: load from FIFO, shift 9 bits, hold the gap, repeat.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (!w_empty) w_state_next = SHIFT;
         SHIFT:   if (r_bitcnt == c_bit_last) w_state_next = GAP;
         GAP:     if (w_gap_done) w_state_next = w_empty ? IDLE : SHIFT;
         default: w_state_next = IDLE;
      endcase
   end

   // Shift register and bit/gap counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shreg  <= '0;
         r_bitcnt <= '0;
         r_gapcnt <= '0;
      end else if (w_pop) begin
         r_shreg  <= w_head;
         r_bitcnt <= '0;
      end else if (r_state == SHIFT) begin
         r_shreg  <= r_shreg >> 1;
         r_bitcnt <= r_bitcnt + 4'd1;
         if (r_bitcnt == c_bit_last) r_gapcnt <= '0;
      end else if (r_state == GAP) begin
         r_gapcnt <= r_gapcnt + 1'b1;
      end
   end

   // Registered serial outputs, one cycle behind the SHIFT state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ser_frame <= 1'b0;
         r_ser_bit   <= 1'b0;
      end else begin
         r_ser_frame <= (r_state == SHIFT);
         r_ser_bit   <= (r_state == SHIFT) && r_shreg[0];
      end
   end

   // Sticky overflow flag and saturating drop counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf_seen   <= 1'b0;
         r_drop_count <= '0;
      end else begin
         if (w_accept && result[SN_WORD_W-1]) r_ovf_seen <= 1'b1;
         if (result_valid && !w_accept && (r_drop_count != 8'hFF))
            r_drop_count <= r_drop_count + 8'd1;
      end
   end

   assign ser_bit    = r_ser_bit;
   assign ser_frame  = r_ser_frame;
   assign busy       = !w_empty || (r_state != IDLE);
   assign fifo_full  = w_full;
   assign ovf_seen   = r_ovf_seen;
   assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_sn_result_serializer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module   : tb_sn_result_serializer                                       |
// | Purpose  : Self-checking bench; a transaction-level model predicts the   |
// |            serial stream and status flags every cycle.                   |
// | Revision : 1.0  initial release                                          |
// ----------------------------------------------------------------------------
module tb_sn_result_serializer;

   localparam int DEPTH     = 4;
   localparam int FRAME_GAP = 1;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       result_valid;
   logic [9:0] result;
   logic       ser_bit;
   logic       ser_frame;
   logic       busy;
   logic       fifo_full;
   logic       ovf_seen;
   logic [7:0] drop_count;

   sn_result_serializer #(
      .DEPTH     (DEPTH),
      .FRAME_GAP (FRAME_GAP)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .result_valid (result_valid),
      .result       (result),
      .ser_bit      (ser_bit),
      .ser_frame    (ser_frame),
      .busy         (busy),
      .fifo_full    (fifo_full),
      .ovf_seen     (ovf_seen),
      .drop_count   (drop_count)
   );

   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;

   // Model: the serializer is free to take a new word every 9+FRAME_GAP edges.
   int         e        = 0;
   int         free_at  = 0;
   int         last_pop = -100;
   logic [8:0] last_word = '0;
   logic [8:0] m_q[$];
   int         m_drops  = 0;
   bit         m_ovf    = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, e);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      free_at  = 0;
      last_pop = e - 100;
      m_drops  = 0;
      m_ovf    = 0;
   endtask

   task automatic model_edge(input bit v, input logic [9:0] w);
      logic [8:0] s;
      e++;
      if (e >= free_at && m_q.size() > 0) begin
         last_word = m_q.pop_front();
         last_pop  = e;
         free_at   = e + 9 + FRAME_GAP;
      end
      if (v) begin
         if (m_q.size() < DEPTH) begin
`ifdef SN_SER_SATURATE_EN
            s = w[9] ? 9'h1FF : w[8:0];
`else
            s = w[8:0];
`endif
            m_q.push_back(s);
            if (w[9]) m_ovf = 1;
         end else if (m_drops < 255) begin
            m_drops++;
         end
      end
   endtask

   task automatic check_outputs();
      int idx;
      bit frm;
      idx = e - last_pop - 1;
      frm = (idx >= 0) && (idx <= 8);
      chk("ser_frame", 32'(ser_frame), 32'(frm));
      chk("ser_bit", 32'(ser_bit), frm ? 32'(last_word[idx]) : 32'd0);
      chk("busy", 32'(busy), 32'((m_q.size() > 0) || (e < free_at)));
      chk("fifo_full", 32'(fifo_full), 32'(m_q.size() == DEPTH));
      chk("ovf_seen", 32'(ovf_seen), 32'(m_ovf));
      chk("drop_count", 32'(drop_count), 32'(m_drops));
   endtask

   task automatic cyc(input bit v, input logic [9:0] w);
      result_valid = v;
      result       = w;
      @(posedge clk);
      model_edge(v, w);
      #1;
      check_outputs();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(1'b0, 10'h000);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_bit"}, 32'(ser_bit), 32'd0);
      chk({tag, "_frame"}, 32'(ser_frame), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_full"}, 32'(fifo_full), 32'd0);
      chk({tag, "_ovf"}, 32'(ovf_seen), 32'd0);
      chk({tag, "_drop"}, 32'(drop_count), 32'd0);
   endtask

   initial begin
      int reached;
      rst_n        = 1'b0;
      result_valid = 1'b0;
      result       = '0;
      #1;
      check_all_zero("reset");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();

      // Single word 0x0A5: bits 1,0,1,0,0,1,0,1,0 then gap, then idle.
      cyc(1'b1, 10'h0A5);
      idle(14);

      // Three back-to-back frames.
      cyc(1'b1, 10'h011);
      cyc(1'b1, 10'h0FF);
      cyc(1'b1, 10'h100);
      idle(35);

      // Burst of 7 into a 4-deep FIFO: exactly 2 drops.
      for (int k = 0; k < 7; k++) cyc(1'b1, 10'(k + 3));
      chk("burst_drops", 32'(drop_count), 32'd2);
      idle(60);

      // Overflow flag word.
      cyc(1'b1, 10'h201);
      chk("ovf_set", 32'(ovf_seen), 32'd1);
      idle(14);

      // Asynchronous reset during bit 4 of a frame.
      cyc(1'b1, 10'h155);
      reached = 0;
      for (int k = 0; k < 20 && reached == 0; k++) begin
         cyc(1'b0, 10'h000);
         if (e - last_pop - 1 == 4) reached = 1;
      end
      chk("reach_bit4", 32'(reached), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("midrst");
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc(1'b1, 10'h0C3);
      idle(14);

      // Random traffic with occasional overflow words.
      for (int k = 0; k < 250; k++)
         cyc(($urandom_range(0, 3) == 0), 10'($urandom));
      idle(60);

      // Long strobe run to saturate the drop counter.
      for (int k = 0; k < 300; k++) cyc(1'b1, 10'($urandom));
      chk("drop_sat", 32'(drop_count), 32'd255);
      idle(60);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sn_result_serializer.md
# sn_result_serializer

Downstream stage of the stochastic multiplier. Captures each 10-bit window result (`{over_flag, prob[8:0]}`) when it is strobed, buffers it in a small FIFO, and re-emits the 9-bit probability as a framed serial bitstream. The stream uses the same format the multiplier's serial input accepts: LSB first, 9 data bits, then a gap. Multiplier stages can therefore be chained, and results can be read off a single pin.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; must be a power of 2, at least 2.
- `FRAME_GAP`, 1: idle cycles after each 9-bit frame; must be at least 1.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `result_valid`  in  1  one-cycle strobe; `result` is valid this cycle.
- `result`  in  10  bit 9 = overflow, bits 8:0 = bipolar probability count.
- `ser_bit`  out  1  serial data, LSB first; 0 when not framing.
- `ser_frame`  out  1  high during the 9 data-bit cycles of a frame.
- `busy`  out  1  high when the FIFO is non-empty or the FSM is not IDLE.
- `fifo_full`  out  1  FIFO holds `DEPTH` entries.
- `ovf_seen`  out  1  sticky; set by any accepted word with bit 9 = 1.
- `drop_count`  out  8  words lost to a full FIFO; saturates at 255.

## Operation
- Write:
  - On a `result_valid` edge, the word is pushed if the FIFO is not full, or if it is full and a pop occurs on the same edge (simultaneous push and pop is legal).
  - Otherwise the word is dropped and `drop_count` increments (saturating at 255).
- `ovf_seen` is set on the edge that pushes a word with bit 9 = 1.
- `ovf_seen` and `drop_count` clear only on reset.
- FSM states: IDLE, SHIFT, GAP.
  - IDLE, FIFO non-empty: pop the head and load `shreg[8:0]`, `bitcnt` = 0, go to SHIFT.
  - IDLE, FIFO empty: stay in IDLE.
  - SHIFT: `ser_frame` = 1 and `ser_bit` = `shreg[0]`. Each edge shifts `shreg` right and increments `bitcnt`. When `bitcnt` = 8, go to GAP with `gapcnt` = 0.
  - GAP: `ser_frame` = 0 and `ser_bit` = 0. When `gapcnt` = `FRAME_GAP`-1: if the FIFO is non-empty, pop and load, and go to SHIFT; otherwise go to IDLE.
- Frame length is exactly 9 + `FRAME_GAP` cycles, with no idle cycle between back-to-back frames.
- `ser_bit` and `ser_frame` are registered outputs; they are not combinational from `result`.
- Reset values:
  - FSM = IDLE, FIFO empty.
  - `ser_bit`, `ser_frame`, `busy`, `fifo_full`, `ovf_seen` = 0; `drop_count` = 0.
- Reset asserted mid-frame: all outputs go to their reset values immediately (asynchronous); the partial frame and FIFO contents are discarded.
- FIFO pointers are log2(`DEPTH`)+1 bits wide and wrap naturally. Full means the MSBs differ and the remaining bits are equal; empty means the pointers are equal.

## Timing
- Edge E0 samples `result_valid` and pushes the word.
- Edge E1: the IDLE FSM pops and loads the word.
- Cycles after E2 through E10: `ser_frame` = 1, carrying bits 0 through 8.
- Cycles after E11 through E(10+`FRAME_GAP`): gap.
- Latency from strobe to first data bit is 2 cycles.
- Sustained throughput is 1 word per 9 + `FRAME_GAP` cycles. The multiplier produces 1 word per 131073 cycles, so the FIFO only absorbs bursts and test stimulus.
- `fifo_full` and `busy` reflect the state after each edge, in the same cycle as the pointer update.

## Configuration
- `SN_SER_SATURATE_EN`:
  - Defined: a pushed word with bit 9 = 1 is stored as 9'h1FF, so the serial stream saturates at full-scale positive.
  - Undefined: bits 8:0 are stored unchanged and overflow is reported only through `ovf_seen`.
- `ovf_seen` behaves identically in both builds.

## Structure
- Package `sn_pkg` holds:
  - `SN_FRAME_BITS` = 9 and `SN_WORD_W` = 10.
  - The FSM state enum `sn_ser_state_t` (IDLE, SHIFT, GAP).
- Sub-module `sn_result_fifo`: synchronous FIFO with parameter `DEPTH`, 9-bit data, push/pop/full/empty.
- The top level contains the FSM, shift register, counters and overflow logic.

## Test plan
- Reset, then strobe `result` = 10'h0A5:
  - `ser_frame` is high for 9 cycles starting 2 cycles after the strobe.
  - `ser_bit` sequence is 1,0,1,0,0,1,0,1,0, followed by 1 gap cycle at 0.
  - `busy` then falls.
- Strobe 10'h011, 10'h0FF, 10'h100 on consecutive cycles:
  - Three back-to-back frames, each 10 cycles.
  - Decoded values are 0x011, 0x0FF, 0x100.
- With `DEPTH` = 4, strobe 7 words on consecutive cycles:
  - The first frame pops after E1, so exactly 2 words are dropped.
  - `drop_count` = 2, `fifo_full` asserts, and 5 frames are emitted.
- Strobe 10'h201:
  - `ovf_seen` = 1.
  - Frame decodes as 0x001 without `SN_SER_SATURATE_EN`, and as 0x1FF with it defined.
- Deassert `rst_n` during bit 4 of a frame:
  - Outputs are 0 immediately and the FIFO is empty.
  - After release, a new strobe produces a clean frame with 2-cycle latency.
- 300 strobes with the serial side kept busy:
  - `drop_count` saturates at 255 and does not wrap.
